// File: rtl/alu_result_flag_unit_4_bit.sv
// ALU output stage: converts raw adder output into result/NZCV for ADD, SUB and SLT,
// buffered in a 2-entry valid/ready FIFO. Define ALU_STATUS_STICKY_EN to enable sticky_v.
module alu_result_flag_unit_4_bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] sum,
    input  logic       carry_out,
    input  logic       a_msb,
    input  logic       b_msb,
    input  logic [2:0] ALUop,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] result,
    output logic       flag_n,
    output logic       flag_z,
    output logic       flag_c,
    output logic       flag_v,
    input  logic       clear_sticky,
    output logic       sticky_v
);

    typedef struct packed {
        logic [3:0] result;
        logic       n;
        logic       z;
        logic       c;
        logic       v;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } count_e;

    count_e count_q;
    entry_t head_q;
    entry_t tail_q;
    entry_t new_entry;
    logic   is_sub;
    logic   is_slt;
    logic   push;
    logic   pop;

    // Upstream complemented B for SUB/SLT, so carry becomes borrow and the
    // overflow test compares A against the original, unconditioned B sign.
    always_comb begin
        new_entry = '0;
        is_sub    = (ALUop == 3'b110) || (ALUop == 3'b111);
        is_slt    = (ALUop == 3'b111);
        if (is_sub) begin
            new_entry.v = (a_msb != b_msb) && (sum[3] != a_msb);
            new_entry.c = ~carry_out;
        end else begin
            new_entry.v = (a_msb == b_msb) && (sum[3] != a_msb);
            new_entry.c = carry_out;
        end
        new_entry.result = is_slt ? {3'b000, sum[3] ^ new_entry.v} : sum;
        new_entry.n      = new_entry.result[3];
        new_entry.z      = (new_entry.result == 4'b0000);
    end

    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // NOTE: the buffer registers are reset too, because result and flags must read 0 during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            case (count_q)
                EMPTY: begin
                    if (push) begin
                        head_q  <= new_entry;
                        count_q <= ONE;
                    end
                end
                ONE: begin
                    case ({push, pop})
                        2'b10: begin
                            tail_q  <= new_entry;
                            count_q <= FULL;
                        end
                        2'b01: count_q <= EMPTY;
                        2'b11: head_q  <= new_entry;
                        default: ;
                    endcase
                end
                FULL: begin
                    if (pop) begin
                        head_q  <= tail_q;
                        count_q <= ONE;
                    end
                end
                default: count_q <= EMPTY;
            endcase
        end
    end

    assign result = head_q.result;
    assign flag_n = head_q.n;
    assign flag_z = head_q.z;
    assign flag_c = head_q.c;
    assign flag_v = head_q.v;

`ifdef ALU_STATUS_STICKY_EN
    // Set has priority over clear when both land on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_v <= 1'b0;
        end else if (pop && head_q.v) begin
            sticky_v <= 1'b1;
        end else if (clear_sticky) begin
            sticky_v <= 1'b0;
        end
    end
`else
    logic unused_clear_sticky;
    assign unused_clear_sticky = clear_sticky;
    assign sticky_v            = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_flag_unit_4_bit.sv
// Directed + random bench for alu_result_flag_unit_4_bit with a queue scoreboard
// and a sticky_v model that follows ALU_STATUS_STICKY_EN.
module tb_alu_result_flag_unit_4_bit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] sum;
    logic       carry_out;
    logic       a_msb;
    logic       b_msb;
    logic [2:0] ALUop;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] result;
    logic       flag_n;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;
    logic       clear_sticky;
    logic       sticky_v;

    int         checks;
    int         failures;
    logic [7:0] sb[$];
    logic       exp_sticky;

    alu_result_flag_unit_4_bit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .sum         (sum),
        .carry_out   (carry_out),
        .a_msb       (a_msb),
        .b_msb       (b_msb),
        .ALUop       (ALUop),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .flag_n      (flag_n),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .flag_v      (flag_v),
        .clear_sticky(clear_sticky),
        .sticky_v    (sticky_v)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected {result, N, Z, C, V}, derived from signed interpretation of the operand signs.
    function automatic logic [7:0] model(input logic [2:0] op, input logic [3:0] s,
                                         input logic co, input logic a, input logic b);
        logic       subtracting;
        logic       ovf;
        logic       cy;
        logic [3:0] r;
        subtracting = op[2] & op[1];
        if (subtracting) begin
            ovf = (a ^ b) & (s[3] ^ a);
            cy  = !co;
        end else begin
            ovf = !(a ^ b) & (s[3] ^ a);
            cy  = co;
        end
        r = (op == 3'b111) ? ((s[3] ^ ovf) ? 4'd1 : 4'd0) : s;
        return {r, r[3], r == 4'd0, cy, ovf};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] s,
                         input logic co, input logic a, input logic b);
        in_valid  = v;
        ALUop     = op;
        sum       = s;
        carry_out = co;
        a_msb     = a;
        b_msb     = b;
    endtask

    // One clock: score the pop and push decided by the model, advance, then check status.
    task automatic step();
        logic       can_push;
        logic [7:0] exp;
        can_push = (sb.size() != 2);
        if (sb.size() != 0 && out_ready) begin
            exp = sb.pop_front();
            check("pop_entry", {result, flag_n, flag_z, flag_c, flag_v}, exp);
`ifdef ALU_STATUS_STICKY_EN
            if (exp[0]) exp_sticky = 1'b1;
            else if (clear_sticky) exp_sticky = 1'b0;
        end else if (clear_sticky) begin
            exp_sticky = 1'b0;
`endif
        end
        if (in_valid && can_push) sb.push_back(model(ALUop, sum, carry_out, a_msb, b_msb));
        @(posedge clk);
        @(negedge clk);
        check("out_valid", out_valid, sb.size() != 0);
        check("in_ready", in_ready, sb.size() != 2);
        check("sticky_v", sticky_v, exp_sticky);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        exp_sticky   = 1'b0;
        rst_n        = 1'b0;
        out_ready    = 1'b0;
        clear_sticky = 1'b0;
        drive(1'b0, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0);

        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_entry", {result, flag_n, flag_z, flag_c, flag_v}, 8'h00);
        check("rst_sticky", sticky_v, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD overflow: visible right after the pushing edge.
        drive(1'b1, 3'b010, 4'b1000, 1'b0, 1'b0, 1'b0);
        step();
        check("add_ovf", {result, flag_n, flag_z, flag_c, flag_v}, 8'h89);
        drive(1'b0, 3'b010, 4'b1000, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        step();

        // SUB equal (3 - 3).
        out_ready = 1'b0;
        drive(1'b1, 3'b110, 4'b0000, 1'b1, 1'b0, 1'b0);
        step();
        check("sub_equal", {result, flag_n, flag_z, flag_c, flag_v}, 8'h04);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();

        // SLT true (2 - 5).
        out_ready = 1'b0;
        drive(1'b1, 3'b111, 4'b1101, 1'b0, 1'b0, 1'b0);
        step();
        check("slt_true", {result, flag_n, flag_z, flag_c, flag_v}, 8'h12);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();

        // Backpressure: three back-to-back pushes, third is held until space frees.
        out_ready = 1'b0;
        drive(1'b1, 3'b010, 4'b1000, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 3'b110, 4'b0000, 1'b1, 1'b0, 1'b0);
        step();
        check("bp_full_in_ready", in_ready, 0);
        drive(1'b1, 3'b111, 4'b1101, 1'b0, 1'b0, 1'b0);
        step();
        check("bp_stall_hold", {result, flag_n, flag_z, flag_c, flag_v}, 8'h89);
        out_ready = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        step();
        check("bp_drained", out_valid, 0);

        // Random traffic across all opcodes.
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            out_ready    = 1'($urandom_range(0, 1));
            clear_sticky = 1'($urandom_range(0, 3) == 0);
            step();
        end
        in_valid     = 1'b0;
        clear_sticky = 1'b0;
        out_ready    = 1'b1;
        step();
        step();

        // Reset mid-operation: discard a full buffer without a clock edge.
        out_ready = 1'b0;
        drive(1'b1, 3'b001, 4'b0110, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 3'b010, 4'b1000, 1'b0, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_in_ready", in_ready, 1);
        sb.delete();
        exp_sticky = 1'b0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        drive(1'b1, 3'b110, 4'b0111, 1'b1, 1'b0, 1'b1);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("post_rst_alone", out_valid, 0);

        // Sticky overflow: set by V1 pop, survives V0 pop, set beats clear, clear alone clears.
        out_ready = 1'b0;
        drive(1'b1, 3'b010, 4'b1000, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 3'b000, 4'b0011, 1'b0, 1'b0, 1'b0);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        drive(1'b1, 3'b010, 4'b1000, 1'b0, 1'b0, 1'b0);
        step();
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        clear_sticky = 1'b1;
        step();
        step();
        clear_sticky = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_result_flag_unit_4_bit.md
# alu_result_flag_unit_4_bit

Output-side companion to the ALU's operand-conditioning stage. The input stage complements B when ALUop selects a subtracting operation. This block takes the raw 4-bit adder output and undoes that view: it turns carry into borrow, derives overflow from the original operand signs, and forms the set-less-than result. It registers result and flags into a 2-entry valid/ready output buffer, so the ALU datapath can stall against a slow consumer.

## Interface
Parameters:
- none (width fixed at 4 bits, matching the ALU datapath)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  adder output and op fields valid this cycle
- in_ready  output  1  buffer can accept; equals (count != 2)
- sum  input  4  raw adder output (B already conditioned upstream)
- carry_out  input  1  adder carry out of bit 3
- a_msb  input  1  bit 3 of operand A
- b_msb  input  1  bit 3 of operand B before conditioning
- ALUop  input  3  operation code
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer accepts head entry
- result  output  4  head entry result
- flag_n, flag_z, flag_c, flag_v  output  1 each  negative, zero, carry/borrow, overflow of head entry
- clear_sticky  input  1  clears sticky_v (see Configuration)
- sticky_v  output  1  sticky overflow

## Operation
- Subtracting ops: ALUop 3'b110 (SUB) and 3'b111 (SLT). All other codes are treated as additive.
- Additive ops: result = sum; C = carry_out; V = (a_msb == b_msb) && (sum[3] != a_msb).
- SUB: result = sum; C = ~carry_out (borrow); V = (a_msb != b_msb) && (sum[3] != a_msb).
- SLT: V is computed as for SUB; result = {3'b000, sum[3] ^ V}; C = ~carry_out.
- N = result[3]; Z = (result == 4'b0000). Both are computed on the final result, so they follow the SLT substitution.
- Buffer: 2-entry FIFO holding {result, N, Z, C, V}.
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - Order is strictly preserved.
- Count states:
  - EMPTY (0): out_valid = 0, in_ready = 1.
  - ONE (1): out_valid = 1, in_ready = 1.
  - FULL (2): out_valid = 1, in_ready = 0.
- Transitions:
  - push only: count + 1.
  - pop only: count − 1.
  - push and pop in ONE: count stays 1 and the head advances to the new entry.
  - In FULL a push is impossible, so only a pop can change the count.
- in_ready depends only on registered count, never combinationally on out_ready.
- When out_valid = 0, the result and flag outputs hold their last value; their content is don't-care.

## Timing
- Latency: an entry pushed at edge N appears on the outputs with out_valid = 1 immediately after edge N, provided it is the head.
- Throughput: 1 entry per cycle when out_ready is held high.
- Outputs stay stable while out_valid = 1 and out_ready = 0.
- Reset is asynchronous. While rst_n = 0: count = 0, out_valid = 0, result = 0, all flags = 0, sticky_v = 0; in_ready reads 1 and no push is taken.
- Reset mid-operation: all buffered entries are discarded immediately, with no wait for a clock edge.
- First push is possible on the first rising edge after rst_n deasserts.

## Configuration
- ALU_STATUS_STICKY_EN defined:
  - sticky_v sets on any pop whose entry has V = 1.
  - sticky_v clears on a clock edge with clear_sticky = 1.
  - If the set and clear conditions occur on the same edge, set wins.
- ALU_STATUS_STICKY_EN undefined:
  - sticky_v is tied to 0 and clear_sticky is ignored.
  - The ports remain present.

## Test plan
- ADD overflow: ALUop 3'b010, sum 4'b1000, carry_out 0, a_msb 0, b_msb 0 → result 4'b1000, N1 Z0 C0 V1, out_valid the cycle after push.
- SUB equal: ALUop 3'b110, sum 4'b0000, carry_out 1, a_msb 0, b_msb 0 (3 − 3) → result 4'b0000, N0 Z1 C0 V0.
- SLT true: ALUop 3'b111, sum 4'b1101, carry_out 0, a_msb 0, b_msb 0 (2 − 5) → result 4'b0001, N0 Z0 C1 V0.
- Backpressure: out_ready = 0, push 3 back-to-back → in_ready drops after the 2nd push and the 3rd is held. Raising out_ready then yields 3 entries in push order.
- Reset mid-operation: FULL buffer, pulse rst_n low between edges → out_valid = 0 and result = 0 immediately. After release, the next push appears alone.
- Sticky (macro on): pop an entry with V1, then an entry with V0 → sticky_v stays 1. Assert clear_sticky on the same edge as a V1 pop → stays 1. Clear with no pop → 0. Macro off → sticky_v always 0.
